jtag_reg_bank_chain: RTL and testbench
======================================

Name: jtag_reg_bank_chain

Overview:
- Parametrised JTAG user-data-register chain.
- Replaces the fixed-width per-instruction chains with one addressed frame format. A single instance exposes NUM_REGS host-writable, host-readable registers, for example LED colour planes and row select.
- Sits between the JTAG primitive's ER1/ER2 signals and the fabric. It adds capture readback, frame-length checking and per-register update strobes.

Parameters:
DATA_W, 10, width of each register and of the frame data field
NUM_REGS, 4, number of registers in the bank (1..2**ADDR_W)
ADDR_W, 2, width of the frame address field
RST_VAL, 0, reset value of every register (DATA_W bits)

Ports:
JTCK  input  1  JTAG test clock; all logic is rising-edge on JTCK
JRST  input  1  synchronous active-high reset
JSEL  input  1  this chain's user instruction is active (JCE1/JCE2 qualifier)
JTDI  input  1  serial data in
JSHIFT  input  1  TAP in Shift-DR
JCE  input  1  chain enable: capture when JSHIFT=0, shift when JSHIFT=1
JUPDATE  input  1  TAP in Update-DR (one-cycle pulse)
JRTI  input  1  TAP in Run-Test/Idle
JTDO  output  1  serial data out
regs_flat  output  NUM_REGS*DATA_W  register bank; reg i at [i*DATA_W +: DATA_W]
upd_strobe  output  NUM_REGS  one-cycle pulse when reg i is written
rti_pulse  output  1  one-cycle pulse on JRTI rising edge while JSEL
frame_err  output  1  sticky: last update rejected (bad length or bad address)

Behaviour:
- Frame: FRAME_W = 1+ADDR_W+DATA_W bits, shifted LSB first.
  - bit0 = wr
  - bits[ADDR_W:1] = addr
  - bits[FRAME_W-1:ADDR_W+1] = data
- Shift register sr[FRAME_W-1:0]. JTDO = sr[0] at all times, registered.
- Capture: cycle with JSEL & JCE & !JSHIFT.
  - sr <= {regs[last_addr], last_addr, frame_err}
  - last_addr is the address of the most recent accepted frame; 0 after reset.
  - bit_cnt <= 0.
- Shift: cycle with JSEL & JCE & JSHIFT.
  - sr <= {JTDI, sr[FRAME_W-1:1]}
  - bit_cnt <= bit_cnt+1, saturating at FRAME_W+1.
- Update: cycle with JSEL & JUPDATE.
  - Accepted only if bit_cnt == FRAME_W and addr < NUM_REGS.
  - Accepted frame: last_addr <= addr and frame_err <= 0.
  - Accepted frame with wr=1: regs[addr] <= data, and upd_strobe[addr] = 1 for exactly the next cycle.
  - Accepted frame with wr=0 (read request): nothing is written; the data appears at the next capture.
  - Rejected frame: frame_err <= 1; no register or last_addr change; no strobe.
  - Update with no prior capture since reset: bit_cnt = 0, so the frame is rejected.
- Without JSEL, capture, shift and update are all ignored; sr and bit_cnt hold.
- rti_pulse: registered JRTI&JSEL edge detect; high one cycle after the first cycle JRTI&JSEL is seen.
- Simultaneous JCE and JUPDATE cannot occur from a legal TAP. If both are asserted, update takes priority and shift/capture is skipped that cycle.
- Reset, effective at any cycle including mid-shift:
  - regs = RST_VAL, sr = 0, bit_cnt = 0, last_addr = 0
  - frame_err = 0, upd_strobe = 0, rti_pulse = 0, JTDO = 0
  - A frame interrupted by reset is discarded.
- Latency:
  - update edge -> regs_flat change: 1 cycle
  - capture -> first readback bit on JTDO: 1 cycle

Test Plan:
- Reset then capture: JRST 2 cycles, capture, shift 13 bits -> JTDO sequence all 0; regs_flat = 0; frame_err = 0.
- Write: shift 13 bits {data=10'h2A5, addr=2'd2, wr=1}, update -> reg2 = 10'h2A5, upd_strobe = 4'b0100 for 1 cycle, others unchanged.
- Readback: after the write, capture and shift 13 bits -> JTDO yields bit0 = 0, addr = 2, data = 10'h2A5 LSB first.
- Length error: shift 12 bits or 14 bits then update -> regs unchanged, no strobe, frame_err = 1. A subsequent valid frame clears frame_err to 0.
- Address range: NUM_REGS = 3, frame addr = 3, wr = 1 -> rejected, frame_err = 1; addr = 1 write succeeds.
- Reset mid-shift after 6 bits, then JSEL = 0 with JUPDATE -> no write, bit_cnt = 0, and a later update is rejected.
- JRTI held 5 cycles with JSEL -> rti_pulse high exactly one cycle; with JSEL = 0 -> no pulse.

Source files
------------

// File: rtl/jtag_reg_bank_chain.sv
// Addressed JTAG user-data-register chain: one frame format {data, addr, wr} shifted LSB first,
// with capture readback of the last accessed register, frame-length checking and per-register strobes.
module jtag_reg_bank_chain #(
  parameter int unsigned        DATA_W   = 10,
  parameter int unsigned        NUM_REGS = 4,
  parameter int unsigned        ADDR_W   = 2,
  parameter logic [DATA_W-1:0]  RST_VAL  = '0
) (
  input  logic                       JTCK,
  input  logic                       JRST,
  input  logic                       JSEL,
  input  logic                       JTDI,
  input  logic                       JSHIFT,
  input  logic                       JCE,
  input  logic                       JUPDATE,
  input  logic                       JRTI,
  output logic                       JTDO,
  output logic [NUM_REGS*DATA_W-1:0] regs_flat,
  output logic [NUM_REGS-1:0]        upd_strobe,
  output logic                       rti_pulse,
  output logic                       frame_err
);

  localparam int unsigned        FRAME_W  = 1 + ADDR_W + DATA_W;
  localparam int unsigned        CNT_W    = $clog2(FRAME_W + 2);
  localparam logic [CNT_W-1:0]   CNT_FULL = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0]   CNT_MAX  = CNT_W'(FRAME_W + 1);
  localparam logic [ADDR_W:0]    ADDR_LIM = (ADDR_W + 1)'(NUM_REGS);

  logic [FRAME_W-1:0]               sr_q, sr_d;
  logic [CNT_W-1:0]                 cnt_q, cnt_d;
  logic [ADDR_W-1:0]                last_addr_q, last_addr_d;
  logic                             err_q, err_d;
  logic [NUM_REGS-1:0][DATA_W-1:0]  regs_q, regs_d;
  logic [NUM_REGS-1:0]              strobe_q, strobe_d;
  logic                             rti_seen_q, rti_pulse_q;

  logic              fr_wr;
  logic [ADDR_W-1:0] fr_addr;
  logic [DATA_W-1:0] fr_data;
  logic              frame_ok;

  assign fr_wr    = sr_q[0];
  assign fr_addr  = sr_q[ADDR_W:1];
  assign fr_data  = sr_q[FRAME_W-1:ADDR_W+1];
  assign frame_ok = (cnt_q == CNT_FULL) && ({1'b0, fr_addr} < ADDR_LIM);

  always_comb begin
    sr_d        = sr_q;
    cnt_d       = cnt_q;
    last_addr_d = last_addr_q;
    err_d       = err_q;
    regs_d      = regs_q;
    strobe_d    = '0;
    // Update outranks capture/shift if an illegal TAP asserts both.
    if (JSEL && JUPDATE) begin
      if (frame_ok) begin
        last_addr_d = fr_addr;
        err_d       = 1'b0;
        if (fr_wr) begin
          for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (fr_addr == ADDR_W'(i)) begin
              regs_d[i]   = fr_data;
              strobe_d[i] = 1'b1;
            end
          end
        end
      end else begin
        err_d = 1'b1;
      end
    end else if (JSEL && JCE) begin
      if (JSHIFT) begin
        sr_d = {JTDI, sr_q[FRAME_W-1:1]};
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
      end else begin
        sr_d  = {regs_q[last_addr_q], last_addr_q, err_q};
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge JTCK) begin
    if (JRST) begin
      sr_q        <= '0;
      cnt_q       <= '0;
      last_addr_q <= '0;
      err_q       <= 1'b0;
      regs_q      <= {NUM_REGS{RST_VAL}};
      strobe_q    <= '0;
      rti_seen_q  <= 1'b0;
      rti_pulse_q <= 1'b0;
    end else begin
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      last_addr_q <= last_addr_d;
      err_q       <= err_d;
      regs_q      <= regs_d;
      strobe_q    <= strobe_d;
      rti_seen_q  <= JRTI & JSEL;
      rti_pulse_q <= JRTI & JSEL & ~rti_seen_q;
    end
  end

  assign JTDO       = sr_q[0];
  assign regs_flat  = regs_q;
  assign upd_strobe = strobe_q;
  assign rti_pulse  = rti_pulse_q;
  assign frame_err  = err_q;

endmodule

// File: tb/tb_jtag_reg_bank_chain.sv
// Directed bench: a 4-register and a 3-register chain share one TAP stimulus; each is checked
// against hand-computed register, strobe, error and readback values.
module tb_jtag_reg_bank_chain;

  logic JTCK = 1'b0;
  logic JRST, JSEL, JTDI, JSHIFT, JCE, JUPDATE, JRTI;
  logic        tdo_a, tdo_b, rti_a, rti_b, err_a, err_b;
  logic [39:0] regs_a;
  logic [29:0] regs_b;
  logic [3:0]  stb_a;
  logic [2:0]  stb_b;

  int vectors = 0;
  int miscompares = 0;

  always #5 JTCK = ~JTCK;

  jtag_reg_bank_chain #(.DATA_W(10), .NUM_REGS(4), .ADDR_W(2), .RST_VAL(10'h000)) dut_a (
    .JTCK(JTCK), .JRST(JRST), .JSEL(JSEL), .JTDI(JTDI), .JSHIFT(JSHIFT), .JCE(JCE),
    .JUPDATE(JUPDATE), .JRTI(JRTI), .JTDO(tdo_a), .regs_flat(regs_a), .upd_strobe(stb_a),
    .rti_pulse(rti_a), .frame_err(err_a));

  jtag_reg_bank_chain #(.DATA_W(10), .NUM_REGS(3), .ADDR_W(2), .RST_VAL(10'h000)) dut_b (
    .JTCK(JTCK), .JRST(JRST), .JSEL(JSEL), .JTDI(JTDI), .JSHIFT(JSHIFT), .JCE(JCE),
    .JUPDATE(JUPDATE), .JRTI(JRTI), .JTDO(tdo_b), .regs_flat(regs_b), .upd_strobe(stb_b),
    .rti_pulse(rti_b), .frame_err(err_b));

  typedef struct {
    int          nbits;
    logic [31:0] bits;
    logic [39:0] regs_a;
    logic [3:0]  stb_a;
    logic        err_a;
    logic [29:0] regs_b;
    logic [2:0]  stb_b;
    logic        err_b;
    logic        rb;
    logic [12:0] rb_exp;
  } vec_t;

  vec_t vt[7];

  function automatic logic [31:0] mkf(input logic wr, input logic [1:0] addr, input logic [9:0] data);
    return {19'b0, data, addr, wr};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge JTCK);
    #1;
  endtask

  task automatic capture();
    JSEL = 1'b1; JCE = 1'b1; JSHIFT = 1'b0;
    tick();
    JCE = 1'b0;
  endtask

  task automatic shift_bits(input logic [31:0] val, input int n,
                            output logic [31:0] ta, output logic [31:0] tb);
    ta = '0;
    tb = '0;
    for (int i = 0; i < n; i++) begin
      ta[i] = tdo_a;
      tb[i] = tdo_b;
      JTDI = val[i]; JCE = 1'b1; JSHIFT = 1'b1;
      tick();
    end
    JCE = 1'b0; JSHIFT = 1'b0; JTDI = 1'b0;
  endtask

  task automatic update();
    JCE = 1'b0; JSHIFT = 1'b0; JUPDATE = 1'b1;
    tick();
    JUPDATE = 1'b0;
  endtask

  initial begin
    logic [31:0] ta, tb;
    int cnt;
    logic first;

    vt[0] = '{13, mkf(1'b1, 2'd2, 10'h2A5), {10'h0, 10'h2A5, 10'h0, 10'h0}, 4'b0100, 1'b0,
              {10'h2A5, 10'h0, 10'h0}, 3'b100, 1'b0, 1'b0, 13'h0};
    vt[1] = '{12, mkf(1'b1, 2'd1, 10'h155), {10'h0, 10'h2A5, 10'h0, 10'h0}, 4'b0000, 1'b1,
              {10'h2A5, 10'h0, 10'h0}, 3'b000, 1'b1, 1'b0, 13'h0};
    vt[2] = '{14, 32'h3FFF, {10'h0, 10'h2A5, 10'h0, 10'h0}, 4'b0000, 1'b1,
              {10'h2A5, 10'h0, 10'h0}, 3'b000, 1'b1, 1'b1, {10'h2A5, 2'd2, 1'b1}};
    vt[3] = '{13, mkf(1'b1, 2'd1, 10'h155), {10'h0, 10'h2A5, 10'h155, 10'h0}, 4'b0010, 1'b0,
              {10'h2A5, 10'h155, 10'h0}, 3'b010, 1'b0, 1'b0, 13'h0};
    vt[4] = '{13, mkf(1'b1, 2'd3, 10'h3FF), {10'h3FF, 10'h2A5, 10'h155, 10'h0}, 4'b1000, 1'b0,
              {10'h2A5, 10'h155, 10'h0}, 3'b000, 1'b1, 1'b0, 13'h0};
    vt[5] = '{13, mkf(1'b0, 2'd2, 10'h000), {10'h3FF, 10'h2A5, 10'h155, 10'h0}, 4'b0000, 1'b0,
              {10'h2A5, 10'h155, 10'h0}, 3'b000, 1'b0, 1'b1, {10'h2A5, 2'd2, 1'b0}};
    vt[6] = '{13, mkf(1'b1, 2'd0, 10'h001), {10'h3FF, 10'h2A5, 10'h155, 10'h001}, 4'b0001, 1'b0,
              {10'h2A5, 10'h155, 10'h001}, 3'b001, 1'b0, 1'b0, 13'h0};

    JRST = 1'b1; JSEL = 1'b0; JTDI = 1'b0; JSHIFT = 1'b0; JCE = 1'b0; JUPDATE = 1'b0; JRTI = 1'b0;
    tick();
    tick();
    JRST = 1'b0;
    check("reset_regs_a", regs_a, 40'h0);
    check("reset_regs_b", regs_b, 30'h0);
    check("reset_err_a", err_a, 1'b0);
    check("reset_stb_a", stb_a, 4'h0);
    check("reset_tdo_a", tdo_a, 1'b0);
    check("reset_rti_a", rti_a, 1'b0);

    capture();
    shift_bits(32'h0, 13, ta, tb);
    check("reset_readback_a", ta[12:0], 13'h0);
    check("reset_readback_b", tb[12:0], 13'h0);

    for (int i = 0; i < 7; i++) begin
      capture();
      shift_bits(vt[i].bits, vt[i].nbits, ta, tb);
      update();
      check($sformatf("v%0d_regs_a", i), regs_a, vt[i].regs_a);
      check($sformatf("v%0d_stb_a", i), stb_a, vt[i].stb_a);
      check($sformatf("v%0d_err_a", i), err_a, vt[i].err_a);
      check($sformatf("v%0d_regs_b", i), regs_b, vt[i].regs_b);
      check($sformatf("v%0d_stb_b", i), stb_b, vt[i].stb_b);
      check($sformatf("v%0d_err_b", i), err_b, vt[i].err_b);
      tick();
      check($sformatf("v%0d_stb_clear_a", i), stb_a, 4'h0);
      check($sformatf("v%0d_stb_clear_b", i), stb_b, 3'h0);
      if (vt[i].rb) begin
        capture();
        shift_bits(32'h0, 13, ta, tb);
        check($sformatf("v%0d_readback_a", i), ta[12:0], vt[i].rb_exp);
        check($sformatf("v%0d_readback_b", i), tb[12:0], vt[i].rb_exp);
      end
    end

    // Reset lands mid-frame with shift still asserted; the partial frame must be lost.
    capture();
    shift_bits(mkf(1'b1, 2'd0, 10'h2AA), 6, ta, tb);
    JRST = 1'b1; JCE = 1'b1; JSHIFT = 1'b1; JTDI = 1'b1;
    tick();
    JRST = 1'b0; JCE = 1'b0; JSHIFT = 1'b0; JTDI = 1'b0;
    check("midrst_regs_a", regs_a, 40'h0);
    check("midrst_regs_b", regs_b, 30'h0);
    check("midrst_err_a", err_a, 1'b0);
    check("midrst_tdo_a", tdo_a, 1'b0);
    JSEL = 1'b0; JUPDATE = 1'b1;
    tick();
    JUPDATE = 1'b0;
    check("nosel_upd_stb_a", stb_a, 4'h0);
    check("nosel_upd_err_a", err_a, 1'b0);
    check("nosel_upd_regs_a", regs_a, 40'h0);
    JSEL = 1'b1;
    update();
    check("postrst_upd_err_a", err_a, 1'b1);
    check("postrst_upd_err_b", err_b, 1'b1);
    check("postrst_upd_stb_a", stb_a, 4'h0);
    check("postrst_upd_regs_a", regs_a, 40'h0);

    JSEL = 1'b1; JRTI = 1'b1;
    cnt = 0;
    first = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 0) first = rti_a;
      if (rti_a) cnt++;
    end
    check("rti_first_cycle", first, 1'b1);
    check("rti_pulse_count", cnt, 1);
    JRTI = 1'b0;
    tick();
    tick();
    JSEL = 1'b0; JRTI = 1'b1;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (rti_a || rti_b) cnt++;
    end
    check("rti_nosel_count", cnt, 0);
    JRTI = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
